ysyx_220053_lsu: RTL

YSYX_220053_LSU -- requirements
Module: ysyx_220053_LSU

---
 rtl/ysyx_220053_lsu.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ysyx_220053_lsu.sv
// Load/store unit: accepts one EXU request, issues one aligned 64-bit memory
// access, and holds the formatted result until the consumer takes it.
module ysyx_220053_lsu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_ren,
   input  logic        in_wen,
   input  logic [2:0]  in_memop,
   input  logic [63:0] in_addr,
   input  logic [63:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [63:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_rdata,
   output logic [4:0]  out_rd,
   output logic        out_rfwen,
   output logic        out_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state;
   logic        ren_q;
   logic        wen_q;
   logic [2:0]  memop_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [4:0]  rd_q;

   logic        misaligned;
   logic        req_err;
   logic [7:0]  size_mask;
   logic [63:0] rd_shifted;
   logic [63:0] load_val;

   // Request validity is judged on the raw inputs so an illegal request never leaves IDLE toward memory.
   always_comb begin
      misaligned = 1'b0;
      case (in_memop[1:0])
         2'd0: misaligned = 1'b0;
         2'd1: misaligned = in_addr[0];
         2'd2: misaligned = |in_addr[1:0];
         2'd3: misaligned = |in_addr[2:0];
         default: misaligned = 1'b0;
      endcase
      req_err = (in_ren & in_wen) | ~(in_ren | in_wen) | (in_ren & (&in_memop)) | misaligned;
   end

   always_comb begin
      size_mask = 8'h00;
      case (memop_q[1:0])
         2'd0: size_mask = 8'h01;
         2'd1: size_mask = 8'h03;
         2'd2: size_mask = 8'h0F;
         2'd3: size_mask = 8'hFF;
         default: size_mask = 8'h00;
      endcase
   end

   always_comb begin
      rd_shifted = mem_rdata >> {addr_q[2:0], 3'b000};
      load_val   = '0;
      case (memop_q)
         3'b000: load_val = {{56{rd_shifted[7]}}, rd_shifted[7:0]};
         3'b001: load_val = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
         3'b010: load_val = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
         3'b011: load_val = rd_shifted;
         3'b100: load_val = {56'd0, rd_shifted[7:0]};
         3'b101: load_val = {48'd0, rd_shifted[15:0]};
         3'b110: load_val = {32'd0, rd_shifted[31:0]};
         default: load_val = '0;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign mem_req   = (state == REQ);
   assign out_valid = (state == DONE);
   assign mem_addr  = {addr_q[63:3], 3'b000};
   assign mem_we    = wen_q;
   assign mem_wmask = wen_q ? (size_mask << addr_q[2:0]) : 8'h00;
   assign mem_wdata = wdata_q << {addr_q[2:0], 3'b000};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ren_q     <= 1'b0;
         wen_q     <= 1'b0;
         memop_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rd_q      <= '0;
         out_rdata <= '0;
         out_rd    <= '0;
         out_rfwen <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  ren_q     <= in_ren;
                  wen_q     <= in_wen;
                  memop_q   <= in_memop;
                  addr_q    <= in_addr;
                  wdata_q   <= in_wdata;
                  rd_q      <= in_rd;
                  out_rd    <= in_rd;
                  out_rdata <= '0;
                  out_rfwen <= 1'b0;
                  out_err   <= req_err;
                  state     <= req_err ? DONE : REQ;
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  state <= ren_q ? WAIT : DONE;
               end
            end
            WAIT: begin
               if (mem_rvalid) begin
                  out_rdata <= load_val;
                  out_rfwen <= (rd_q != 5'd0);
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
